// File: rtl/logit_aprox_seq_pkg.sv
// -----------------------------------------------------------------------------
// logit_aprox_seq_pkg
// Shared definitions for the multicycle logit approximator:
//   - Q8.8 constants (ONE, HALF)
//   - default saturation results for p == 0 and p >= 1.0
//   - FSM state encoding
//   - input decode helper folding p onto the distance from the nearest rail
// -----------------------------------------------------------------------------
package logit_aprox_seq_pkg;

  localparam logic [15:0] ONE         = 16'h0100;
  localparam logic [7:0]  HALF        = 8'h80;
  localparam logic [15:0] SAT_NEG_DEF = 16'h8000;
  localparam logic [15:0] SAT_POS_DEF = 16'h7FFF;
  localparam int          MAX_SHIFT_DEF = 7;

  localparam int Q_W = 9;  // folded distance, 0..128
  localparam int N_W = 3;  // shift count, 0..7

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic           s;  // 1: p on the upper half, result positive
    logic [Q_W-1:0] q;  // distance from the nearest rail
  } fold_t;

  // Anything at or above 1.0 collapses to exactly 1.0, which then folds
  // onto q == 0 on the positive side and saturates.
  function automatic fold_t fold_p(input logic [15:0] p);
    fold_t          r;
    logic [Q_W-1:0] p9;
    p9  = (p >= ONE) ? 9'd256 : {1'b0, p[7:0]};
    r.s = (p9 >= {1'b0, HALF});
    r.q = r.s ? (9'd256 - p9) : p9;
    return r;
  endfunction

endpackage

// File: rtl/logit_aprox_seq_norm.sv
// -----------------------------------------------------------------------------
// logit_norm
// Registered normalise-shift stage. Loads a 9-bit magnitude and doubles it one
// bit per cycle (while step is high) until it reaches [64,128], is zero, or
// the shift count hits MAX_SHIFT. done is registered alongside q and n so the
// owner can branch on it in the same cycle it sees the final q/n.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   load         capture q_in, clear n
//   step         perform one shift if not yet done
//   q_in         magnitude to normalise
//   q_out/n_out  current mantissa and shift count
//   done         normalisation finished
// -----------------------------------------------------------------------------
module logit_norm
  import logit_aprox_seq_pkg::*;
#(
  parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [Q_W-1:0] q_in,
  output logic [Q_W-1:0] q_out,
  output logic [N_W-1:0] n_out,
  output logic           done
);

  logic [Q_W-1:0] q_q, q_d;
  logic [N_W-1:0] n_q, n_d;
  logic           done_q, done_d;

  function automatic logic norm_done(input logic [Q_W-1:0] q,
                                     input logic [N_W-1:0] n);
    return (q == '0) || (q >= 9'd64) || (n == N_W'(MAX_SHIFT));
  endfunction

  always_comb begin
    q_d    = q_q;
    n_d    = n_q;
    done_d = done_q;
    if (load) begin
      q_d    = q_in;
      n_d    = '0;
      done_d = norm_done(q_in, '0);
    end else if (step && !done_q) begin
      // q < 64 here, so the doubling cannot overflow 9 bits
      q_d    = q_q << 1;
      n_d    = n_q + 1'b1;
      done_d = norm_done(q_q << 1, n_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q    <= '0;
      n_q    <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      n_q    <= n_d;
      done_q <= done_d;
    end
  end

  assign q_out = q_q;
  assign n_out = n_q;
  assign done  = done_q;

endmodule

// File: rtl/logit_aprox_seq.sv
// -----------------------------------------------------------------------------
// logit_aprox_seq
// Multicycle approximation of x = logit(p), p unsigned Q8.8 in [0,1], x signed
// Q8.8. The distance q from the nearest rail is normalised to m in [64,128]
// by n doublings; the result magnitude is n + (128 - m)/64, signed by side.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    input handshake (ready only in IDLE)
//   in_p                 probability, >= 16'h0100 treated as 1.0
//   out_valid/out_ready  output handshake, result held until taken
//   out_x                signed Q8.8 logit
//   busy                 high whenever not IDLE
// -----------------------------------------------------------------------------
module logit_aprox_seq
  import logit_aprox_seq_pkg::*;
#(
  parameter logic [15:0] SAT_NEG   = SAT_NEG_DEF,
  parameter logic [15:0] SAT_POS   = SAT_POS_DEF,
  parameter int          MAX_SHIFT = MAX_SHIFT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_x,
  output logic        busy
);

  state_e         state_q, state_d;
  logic           s_q, s_d;
  logic [15:0]    out_x_q, out_x_d;

  logic           norm_load;
  logic           norm_step;
  logic [Q_W-1:0] norm_q;
  logic [N_W-1:0] norm_n;
  logic           norm_done;
  fold_t          in_fold;

  assign in_fold = fold_p(in_p);

  logit_norm #(
    .MAX_SHIFT (MAX_SHIFT)
  ) u_norm (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (norm_load),
    .step  (norm_step),
    .q_in  (in_fold.q),
    .q_out (norm_q),
    .n_out (norm_n),
    .done  (norm_done)
  );

  // Linear correction plus sign; q == 0 means p sat on a rail.
  function automatic logic [15:0] calc_result(input logic [Q_W-1:0] q,
                                              input logic [N_W-1:0] n,
                                              input logic           s);
    logic signed [15:0] mag;
    logic [Q_W-1:0]     frac;
    if (q == '0) begin
      return s ? SAT_POS : SAT_NEG;
    end
    frac = 9'd128 - q;  // q in [64,128] here, so frac fits in 7 bits
    mag  = $signed({5'b0, n, 8'h00}) + $signed({5'b0, frac, 2'b00});
    return s ? mag : -mag;
  endfunction

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    out_x_d   = out_x_q;
    norm_load = 1'b0;
    norm_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          norm_load = 1'b1;
          s_d       = in_fold.s;
          state_d   = NORM;
        end
      end
      NORM: begin
        if (norm_done) state_d = CALC;
        else           norm_step = 1'b1;
      end
      CALC: begin
        out_x_d = calc_result(norm_q, norm_n, s_q);
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      out_x_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      out_x_q <= out_x_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_x     = out_x_q;

endmodule
